// File: rtl/mem_pkg.sv
// Shared types and helpers for the data memory responder: size codes, FSM states,
// access-shape computation and lane/byte mask helpers.
package mem_pkg;

    typedef logic [1:0] size_t;

    localparam size_t SZ_NONE = 2'd0;
    localparam size_t SZ_B    = 2'd1;
    localparam size_t SZ_H    = 2'd2;
    localparam size_t SZ_W    = 2'd3;

    typedef enum logic {IDLE, SECOND} state_t;

    typedef struct packed {
        logic       split;
        logic [2:0] cnt;
    } shape_t;

    // Byte count of the access and whether it spills into the next word.
    function automatic shape_t access_shape(input logic [1:0] off, input size_t sz);
        shape_t s;
        case (sz)
            SZ_B:    s.cnt = 3'd1;
            SZ_H:    s.cnt = 3'd2;
            SZ_W:    s.cnt = 3'd4;
            default: s.cnt = 3'd0;
        endcase
        s.split = ({1'b0, off} + s.cnt) > 3'd4;
        return s;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] n);
        case (n)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] expand_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

endpackage

// File: rtl/byte_mask_ram.sv
// Single-port word RAM with per-byte write mask and one-cycle registered read.
// Read data reflects the word addressed in the previous cycle.
module byte_mask_ram #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [3:0]                     wmask,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: little-endian lane placement over a word RAM, with accesses
// that straddle a word boundary split into two beats by a small FSM.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic          wr,
    input  logic          b_e,
    input  logic          h_e,
    input  logic          w_e,
    input  logic [31:0]   w_data,
    input  logic [15:0]   h_data,
    input  logic [7:0]    b_data,
    output logic [31:0]   rdata,
    output logic          rvalid,
    output logic          busy,
    output logic          err
);

    localparam int            IW      = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH_WORDS);

    state_t        state_q, state_d;
    logic [1:0]    a_off_q, a_off_d;
    logic [2:0]    a_cnt_q, a_cnt_d;
    logic          a_wr_q, a_wr_d;
    logic [AW-1:0] a_widx_q, a_widx_d;
    logic [31:0]   a_data_q, a_data_d;
    logic          a_oob_q, a_oob_d;
    logic [31:0]   merge_q, merge_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic          r_split_q, r_split_d;
    logic [1:0]    r_off_q, r_off_d;
    logic [2:0]    r_cnt_q, r_cnt_d;
    logic          r_oob_q, r_oob_d;

    size_t         in_sz;
    shape_t        in_shape;
    logic [31:0]   in_data;
    logic [1:0]    in_off;
    logic [AW-1:0] in_widx;
    logic          in_oob;
    logic          sec_oob;
    logic [2:0]    n1, n2;
    logic [IW-1:0] ram_addr;
    logic [3:0]    ram_wmask;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [31:0]   rd_word, assembled;

    always_comb begin
        in_sz    = w_e ? SZ_W : h_e ? SZ_H : b_e ? SZ_B : SZ_NONE;
        in_data  = w_e ? w_data : h_e ? {16'h0, h_data} : {24'h0, b_data};
        in_off   = addr[1:0];
        in_shape = access_shape(in_off, in_sz);
        in_widx  = {2'b00, addr[AW-1:2]};
        in_oob   = in_widx >= DEPTH_W;
        sec_oob  = a_widx_q >= DEPTH_W;
        n1       = in_shape.split ? (3'd4 - {1'b0, in_off}) : in_shape.cnt;
        n2       = a_cnt_q + {1'b0, a_off_q} - 3'd4;

        state_d   = state_q;
        a_off_d   = a_off_q;
        a_cnt_d   = a_cnt_q;
        a_wr_d    = a_wr_q;
        a_widx_d  = a_widx_q;
        a_data_d  = a_data_q;
        a_oob_d   = a_oob_q;
        merge_d   = merge_q;
        r_split_d = r_split_q;
        r_off_d   = r_off_q;
        r_cnt_d   = r_cnt_q;
        r_oob_d   = r_oob_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        ram_addr  = in_widx[IW-1:0];
        ram_wmask = 4'b0000;
        ram_wdata = in_data << {in_off, 3'b000};

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (wr && !in_oob) ram_wmask = lane_mask(n1) << in_off;
                    a_off_d   = in_off;
                    a_cnt_d   = in_shape.cnt;
                    a_wr_d    = wr;
                    a_widx_d  = in_widx + 1'b1;
                    a_data_d  = in_data;
                    a_oob_d   = in_oob;
                    r_split_d = 1'b0;
                    r_off_d   = in_off;
                    r_cnt_d   = in_shape.cnt;
                    r_oob_d   = in_oob;
                    if (in_shape.split) begin
                        state_d = SECOND;
                    end else begin
                        rvalid_d = !wr;
                        err_d    = in_oob && (in_shape.cnt != 3'd0);
                    end
                end
            end
            SECOND: begin
                ram_addr  = a_widx_q[IW-1:0];
                ram_wdata = a_data_q >> {(3'd4 - {1'b0, a_off_q}), 3'b000};
                if (a_wr_q && !sec_oob) ram_wmask = lane_mask(n2);
                // RAM output now holds the first-beat word; keep its upper lanes.
                if (!a_wr_q) merge_d = a_oob_q ? 32'h0 : (ram_rdata >> {a_off_q, 3'b000});
                r_split_d = 1'b1;
                r_off_d   = a_off_q;
                r_cnt_d   = a_cnt_q;
                r_oob_d   = sec_oob;
                rvalid_d  = !a_wr_q;
                err_d     = a_oob_q || sec_oob;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A reset cycle must not commit the beat that was in flight.
        if (!rst_n) ram_wmask = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_off_q   <= '0;
            a_cnt_q   <= '0;
            a_wr_q    <= 1'b0;
            a_widx_q  <= '0;
            a_data_q  <= '0;
            a_oob_q   <= 1'b0;
            merge_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            r_split_q <= 1'b0;
            r_off_q   <= '0;
            r_cnt_q   <= '0;
            r_oob_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_off_q   <= a_off_d;
            a_cnt_q   <= a_cnt_d;
            a_wr_q    <= a_wr_d;
            a_widx_q  <= a_widx_d;
            a_data_q  <= a_data_d;
            a_oob_q   <= a_oob_d;
            merge_q   <= merge_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            r_split_q <= r_split_d;
            r_off_q   <= r_off_d;
            r_cnt_q   <= r_cnt_d;
            r_oob_q   <= r_oob_d;
        end
    end

    byte_mask_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .wmask (ram_wmask),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_word   = r_oob_q ? 32'h0 : ram_rdata;
        assembled = r_split_q ? (merge_q | (rd_word << {(3'd4 - {1'b0, r_off_q}), 3'b000}))
                              : (rd_word >> {r_off_q, 3'b000});
        rdata     = rvalid_q ? (assembled & expand_mask(lane_mask(r_cnt_q))) : 32'h0;
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign busy   = (state_q == SECOND);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder against a byte-array model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int TOP   = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        wr = 1'b0;
    logic        b_e = 1'b0, h_e = 1'b0, w_e = 1'b0;
    logic [31:0] w_data = '0;
    logic [15:0] h_data = '0;
    logic [7:0]  b_data = '0;
    logic [31:0] rdata;
    logic        rvalid, busy, err;

    int tests = 0;
    int fails = 0;
    bit [7:0] mdl [TOP];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .AW(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .wr(wr),
        .b_e(b_e), .h_e(h_e), .w_e(w_e),
        .w_data(w_data), .h_data(h_data), .b_data(b_data),
        .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req = 1'b0; wr = 1'b0; {w_e, h_e, b_e} = 3'b000;
    endtask

    // Called at a falling edge; returns at the falling edge of the result cycle.
    task automatic access(input bit w, input bit [2:0] en, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got);
        int       cnt;
        bit       split, any_oob;
        logic [31:0] exp_rd;
        longint unsigned ba;
        cnt     = en[2] ? 4 : en[1] ? 2 : en[0] ? 1 : 0;
        split   = ((a % 4) + cnt) > 4;
        exp_rd  = '0;
        any_oob = 1'b0;
        for (int k = 0; k < cnt; k++) begin
            ba = longint'(a) + k;
            if (ba >= TOP) any_oob = 1'b1;
            else if (w) mdl[ba] = d[8*k +: 8];
            else exp_rd[8*k +: 8] = mdl[ba];
        end
        req = 1'b1; wr = w; {w_e, h_e, b_e} = en; addr = a;
        w_data = d; h_data = d[15:0]; b_data = d[7:0];
        @(posedge clk); @(negedge clk);
        if (split) begin
            check("busy_split", {31'b0, busy}, 32'd1);
            check("rvalid_beat1", {31'b0, rvalid}, 32'd0);
            check("err_beat1", {31'b0, err}, 32'd0);
            // Stray store while busy must be ignored.
            req = 1'b1; wr = 1'b1; {w_e, h_e, b_e} = 3'b100;
            addr = $urandom_range(0, 60); w_data = $urandom;
            @(posedge clk); @(negedge clk);
        end
        idle_inputs();
        check("busy_done", {31'b0, busy}, 32'd0);
        check("err", {31'b0, err}, {31'b0, any_oob});
        if (!w) begin
            check("rvalid", {31'b0, rvalid}, 32'd1);
            check("rdata", rdata, exp_rd);
        end
        got = rdata;
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [31:0] saved34;

        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) access(1'b1, 3'b100, 32'(4*i), $urandom, got);
        access(1'b1, 3'b100, 32'(TOP-8), $urandom, got);
        access(1'b1, 3'b100, 32'(TOP-4), $urandom, got);

        access(1'b1, 3'b100, 32'h10, 32'hDEADBEEF, got);
        access(1'b0, 3'b100, 32'h10, 32'h0, got);
        check("tp_word", got, 32'hDEADBEEF);
        access(1'b1, 3'b001, 32'h13, 32'h000000AA, got);
        access(1'b0, 3'b100, 32'h10, 32'h0, got);
        check("tp_byte_merge", got, 32'hAAADBEEF);
        access(1'b0, 3'b001, 32'h13, 32'h0, got);
        check("tp_byte_load", got, 32'h000000AA);

        access(1'b1, 3'b100, 32'h20, 32'h0, got);
        access(1'b1, 3'b100, 32'h24, 32'h0, got);
        access(1'b1, 3'b010, 32'h23, 32'h1234, got);
        access(1'b0, 3'b100, 32'h20, 32'h0, got);
        check("tp_split_lo", got, 32'h34000000);
        access(1'b0, 3'b100, 32'h24, 32'h0, got);
        check("tp_split_hi", got, 32'h00000012);
        access(1'b0, 3'b010, 32'h23, 32'h0, got);
        check("tp_split_half", got, 32'h00001234);

        access(1'b0, 3'b100, 32'(TOP-2), 32'h0, got);
        check("tp_top_upper", {16'h0, got[31:16]}, 32'h0);
        access(1'b0, 3'b000, 32'h8, 32'h0, got);
        check("tp_noop", got, 32'h0);

        access(1'b1, 3'b100, 32'h30, 32'h11223344, got);
        access(1'b1, 3'b100, 32'h34, 32'h55667788, got);
        saved34 = 32'h55667788;
        req = 1'b1; wr = 1'b1; {w_e, h_e, b_e} = 3'b100; addr = 32'h31; w_data = 32'hC0FFEE99;
        @(posedge clk); @(negedge clk);
        check("rst2_busy", {31'b0, busy}, 32'd1);
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst2_rdata", rdata, 32'h0);
        check("rst2_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst2_busy_after", {31'b0, busy}, 32'd0);
        check("rst2_err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        mdl[32'h31] = 8'h99; mdl[32'h32] = 8'hEE; mdl[32'h33] = 8'hFF;
        access(1'b0, 3'b100, 32'h30, 32'h0, got);
        check("rst2_first_beat", got, 32'hFFEE9944);
        access(1'b0, 3'b100, 32'h34, 32'h0, got);
        check("rst2_second_dropped", got, saved34);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) a = 32'(TOP - 8 + $urandom_range(0, 10));
            else a = $urandom_range(0, 55);
            access(1'($urandom), 3'($urandom), a, $urandom, got);
        end
        for (int i = 0; i < 16; i++) access(1'b0, 3'b100, 32'(4*i), 32'h0, got);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
